multi_roi_color_detector: RTL
=============================

MULTI_ROI_COLOR_DETECTOR -- requirements
Module: multi_roi_color_detector

Interface
REQ-001 Param NUM_ROI, default 4: number of independent ROIs, legal range 1..8.
REQ-002 Param FB_Y_OFFSET, default 240: VGA row of frame-buffer row 0; frame buffer is 320x240 at x 0..319.
REQ-003 Param MIN_PIXEL_THRESHOLD, default 200: minimum R/G/B pixel count to accept a colour.
REQ-004 Param WHITE_PIXEL_THRESHOLD, default 5000: minimum white count to flag white.
REQ-005 Param STABLE_FRAMES, default 3, range 1..15: identical consecutive raw results required before a stable update.
REQ-006 Ports: clk  in  1  system clock; reset  in  1  asynchronous, active-high reset.
REQ-007 DE  in  1  display enable; x_pixel  in  10  VGA column; y_pixel  in  10  VGA row; pixel_rgb_data  in  16  RGB565 pixel.
REQ-008 roi_x0/roi_x1/roi_y0/roi_y1  in  NUM_ROI*10 each  per-ROI bounds in frame-buffer space, inclusive start, exclusive end, sampled at frame start.
REQ-009 stable_color  out  NUM_ROI*2  00 NONE, 01 RED, 10 GREEN, 11 BLUE; roi_white  out  NUM_ROI  white level per ROI.
REQ-010 result_ready  out  NUM_ROI  one-cycle pulse when that ROI's stable_color changes to non-NONE; frame_done  out  1  one-cycle pulse per evaluated frame.

Function
REQ-011 Pixel valid = DE and x_pixel<320 and FB_Y_OFFSET<=y_pixel<FB_Y_OFFSET+240; frame-buffer y = y_pixel-FB_Y_OFFSET.
REQ-012 RGB565 expanded by zero-padding LSBs to 8 bits; thresholds: red R>=170,G<=100,B<=100; green R<=90,G>=210,B<=90; blue R<=100,G<=100,B>=170; white all >=150; first match in order red, green, blue, white.
REQ-013 Classification is registered one stage; each ROI counter (16-bit, saturating at 65535) increments the cycle after a matching in-ROI pixel.
REQ-014 FSM states IDLE, ACCUM, EVAL, PUBLISH; IDLE->ACCUM on first valid pixel at y=0,x=0, capturing ROI bounds and clearing counters.
REQ-015 ACCUM->EVAL the cycle after the registered pixel at (319,239); valid pixels outside ACCUM are ignored.
REQ-016 EVAL processes one ROI per cycle (NUM_ROI cycles): raw = max of R/G/B counts if >= MIN_PIXEL_THRESHOLD else NONE; ties resolve red>green>blue; raw_white = white count >= WHITE_PIXEL_THRESHOLD.
REQ-017 Per ROI, a 4-bit match counter increments when raw equals the previous frame's raw, else reloads 1; at STABLE_FRAMES stable_color and roi_white update.
REQ-018 PUBLISH lasts one cycle: frame_done and result_ready pulses asserted, counters cleared, next state ACCUM-armed IDLE.
REQ-019 A frame start arriving while in ACCUM aborts accumulation: counters cleared, no evaluation, no frame_done.
REQ-020 ROI with x0>=x1 or y0>=y1 is empty; its counts stay 0 and raw is NONE.

Reset
REQ-021 On reset: FSM IDLE, all counters and match counters 0, stable_color 0, roi_white 0, result_ready 0, frame_done 0; reset mid-frame discards partial data.

Configuration
REQ-022 Macro MULTI_ROI_WHITE_EN defined: white counters and roi_white logic present per REQ-016/017.
REQ-023 MULTI_ROI_WHITE_EN undefined: no white counters; white pixels counted nowhere; roi_white tied 0.

Structure
REQ-024 Package color_detect_pkg holds color_t enum (NONE/RED/GREEN/BLUE), the eight threshold constants, and FB width/height constants.
REQ-025 Sub-module roi_pixel_counter (one instance per ROI: in-ROI test, class counters, saturation, clear).

Verification
REQ-026 Solid red frame, ROI0=(100,220,60,180), 3 frames -> stable_color[1:0]=01 after third frame_done, result_ready[0] pulses once.
REQ-027 ROI1 containing 150 green pixels only -> raw NONE, stable_color[3:2] stays 00.
REQ-028 White frame (0xFFFF) 3 frames, white enabled -> roi_white all 1, stable_color 00; macro off -> roi_white 0.
REQ-029 Alternating red/blue frames -> stable_color never changes from 00, frame_done every frame.
REQ-030 Reset asserted at pixel (160,120) of frame 2 -> all outputs 0 next cycle; next full frame counts from zero.
REQ-031 Equal 300 red and 300 blue pixels in ROI -> raw RED per tie rule.

Source files
------------

// File: rtl/color_detect_pkg.sv
// color_detect_pkg: shared types, colour thresholds and frame-buffer geometry
// for the multi-ROI colour detector. The white class is always reported by the
// classifier; whether anything counts it depends on MULTI_ROI_WHITE_EN.
package color_detect_pkg;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;

   localparam logic [7:0] RED_R_MIN   = 8'd170;
   localparam logic [7:0] RED_GB_MAX  = 8'd100;
   localparam logic [7:0] GREEN_R_MAX = 8'd90;
   localparam logic [7:0] GREEN_G_MIN = 8'd210;
   localparam logic [7:0] GREEN_B_MAX = 8'd90;
   localparam logic [7:0] BLUE_RG_MAX = 8'd100;
   localparam logic [7:0] BLUE_B_MIN  = 8'd170;
   localparam logic [7:0] WHITE_MIN   = 8'd150;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      RED   = 2'b01,
      GREEN = 2'b10,
      BLUE  = 2'b11
   } color_t;

   typedef enum logic [2:0] {
      PC_NONE,
      PC_RED,
      PC_GREEN,
      PC_BLUE,
      PC_WHITE
   } pixel_class_t;

   // Expand RGB565 to 8 bits per channel (zero LSBs) and pick the first
   // matching class in the order red, green, blue, white.
   function automatic pixel_class_t classify_rgb565(input logic [15:0] rgb);
      logic [7:0]   r;
      logic [7:0]   g;
      logic [7:0]   b;
      pixel_class_t c;
      r = {rgb[15:11], 3'b000};
      g = {rgb[10:5], 2'b00};
      b = {rgb[4:0], 3'b000};
      c = PC_NONE;
      if (r >= RED_R_MIN && g <= RED_GB_MAX && b <= RED_GB_MAX)
         c = PC_RED;
      else if (r <= GREEN_R_MAX && g >= GREEN_G_MIN && b <= GREEN_B_MAX)
         c = PC_GREEN;
      else if (r <= BLUE_RG_MAX && g <= BLUE_RG_MAX && b >= BLUE_B_MIN)
         c = PC_BLUE;
      else if (r >= WHITE_MIN && g >= WHITE_MIN && b >= WHITE_MIN)
         c = PC_WHITE;
      return c;
   endfunction

endpackage

// File: rtl/roi_pixel_counter.sv
// roi_pixel_counter: per-ROI bound capture, in-ROI test and saturating class
// counters. The white counter exists only when MULTI_ROI_WHITE_EN is defined.
module roi_pixel_counter
   import color_detect_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         frame_start,
   input  logic         clear,
   input  logic         count_en,
   input  logic [9:0]   pix_x,
   input  logic [9:0]   pix_y,
   input  pixel_class_t pix_class,
   input  logic [9:0]   x0,
   input  logic [9:0]   x1,
   input  logic [9:0]   y0,
   input  logic [9:0]   y1,
   output logic [15:0]  red_count,
   output logic [15:0]  green_count,
   output logic [15:0]  blue_count
`ifdef MULTI_ROI_WHITE_EN
   ,
   output logic [15:0]  white_count
`endif
);

   logic [9:0] x0_q;
   logic [9:0] x1_q;
   logic [9:0] y0_q;
   logic [9:0] y1_q;
   logic       in_roi;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Bounds are frozen at frame start so mid-frame changes cannot skew counts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0_q <= '0;
         x1_q <= '0;
         y0_q <= '0;
         y1_q <= '0;
      end else if (frame_start) begin
         x0_q <= x0;
         x1_q <= x1;
         y0_q <= y0;
         y1_q <= y1;
      end
   end

   // Inclusive start, exclusive end; an inverted or zero-size ROI never matches.
   assign in_roi = (pix_x >= x0_q) && (pix_x < x1_q) &&
                   (pix_y >= y0_q) && (pix_y < y1_q);

   // Class counters: cleared on frame start or publish, saturate at 65535.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         red_count   <= '0;
         green_count <= '0;
         blue_count  <= '0;
`ifdef MULTI_ROI_WHITE_EN
         white_count <= '0;
`endif
      end else if (frame_start || clear) begin
         red_count   <= '0;
         green_count <= '0;
         blue_count  <= '0;
`ifdef MULTI_ROI_WHITE_EN
         white_count <= '0;
`endif
      end else if (count_en && in_roi) begin
         case (pix_class)
            PC_RED:   red_count   <= sat_inc(red_count);
            PC_GREEN: green_count <= sat_inc(green_count);
            PC_BLUE:  blue_count  <= sat_inc(blue_count);
`ifdef MULTI_ROI_WHITE_EN
            PC_WHITE: white_count <= sat_inc(white_count);
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multi_roi_color_detector.sv
// multi_roi_color_detector: classifies RGB565 pixels of a 320x240 frame buffer
// shown inside a VGA raster, counts colours per ROI, and publishes a colour
// per ROI once the same raw result repeats for STABLE_FRAMES frames.
// Optional white detection is compiled in with MULTI_ROI_WHITE_EN.
module multi_roi_color_detector
   import color_detect_pkg::*;
#(
   parameter int NUM_ROI               = 4,
   parameter int FB_Y_OFFSET           = 240,
   parameter int MIN_PIXEL_THRESHOLD   = 200,
   parameter int WHITE_PIXEL_THRESHOLD = 5000,
   parameter int STABLE_FRAMES         = 3
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  DE,
   input  logic [9:0]            x_pixel,
   input  logic [9:0]            y_pixel,
   input  logic [15:0]           pixel_rgb_data,
   input  logic [NUM_ROI*10-1:0] roi_x0,
   input  logic [NUM_ROI*10-1:0] roi_x1,
   input  logic [NUM_ROI*10-1:0] roi_y0,
   input  logic [NUM_ROI*10-1:0] roi_y1,
   output logic [NUM_ROI*2-1:0]  stable_color,
   output logic [NUM_ROI-1:0]    roi_white,
   output logic [NUM_ROI-1:0]    result_ready,
   output logic                  frame_done
);

   localparam int                IDX_W         = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;
   localparam logic [9:0]        X_END         = 10'(FB_WIDTH);
   localparam logic [9:0]        Y_START       = 10'(FB_Y_OFFSET);
   localparam logic [10:0]       Y_END         = 11'(FB_Y_OFFSET + FB_HEIGHT);
   localparam logic [9:0]        X_LAST        = 10'(FB_WIDTH - 1);
   localparam logic [9:0]        Y_LAST        = 10'(FB_HEIGHT - 1);
   localparam logic [15:0]       MIN_COUNT     = 16'(MIN_PIXEL_THRESHOLD);
   localparam logic [3:0]        STABLE_TARGET = 4'(STABLE_FRAMES);
   localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(NUM_ROI - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, EVAL, PUBLISH} state_t;

   state_t       state;
   state_t       next_state;

   logic         pix_valid;
   logic [9:0]   fb_y;
   logic         frame_start;
   logic         frame_start_go;
   logic         count_en;
   logic         last_pixel;

   logic         p_valid;
   logic [9:0]   p_x;
   logic [9:0]   p_y;
   pixel_class_t p_class;

   logic [15:0]  red_cnt   [NUM_ROI];
   logic [15:0]  green_cnt [NUM_ROI];
   logic [15:0]  blue_cnt  [NUM_ROI];

   logic [IDX_W-1:0]   eval_idx;
   logic [15:0]        sel_red;
   logic [15:0]        sel_green;
   logic [15:0]        sel_blue;
   logic [15:0]        best_count;
   color_t             best_color;
   color_t             raw_color;
   logic               same_raw;
   logic [3:0]         new_match;

   color_t             prev_color [NUM_ROI];
   color_t             stable_q   [NUM_ROI];
   logic [3:0]         match_cnt  [NUM_ROI];
   logic [NUM_ROI-1:0] ready_flag;

`ifdef MULTI_ROI_WHITE_EN
   localparam logic [15:0] WHITE_COUNT = 16'(WHITE_PIXEL_THRESHOLD);
   logic [15:0]        white_cnt [NUM_ROI];
   logic [15:0]        sel_white;
   logic               raw_white;
   logic [NUM_ROI-1:0] prev_white;
   logic [NUM_ROI-1:0] white_q;
`endif

   assign pix_valid   = DE && (x_pixel < X_END) && (y_pixel >= Y_START) &&
                        ({1'b0, y_pixel} < Y_END);
   assign fb_y        = y_pixel - Y_START;
   assign frame_start = pix_valid && (x_pixel == 10'd0) && (fb_y == 10'd0);

   assign frame_start_go = frame_start && ((state == IDLE) || (state == ACCUM));
   assign count_en       = p_valid && (state == ACCUM);
   assign last_pixel     = p_valid && (p_x == X_LAST) && (p_y == Y_LAST);

   // One pipeline stage of pixel classification ahead of the counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_valid <= 1'b0;
         p_x     <= '0;
         p_y     <= '0;
         p_class <= PC_NONE;
      end else begin
         p_valid <= pix_valid;
         p_x     <= x_pixel;
         p_y     <= fb_y;
         p_class <= classify_rgb565(pixel_rgb_data);
      end
   end

   for (genvar i = 0; i < NUM_ROI; i++) begin : g_roi
      roi_pixel_counter u_counter (
         .clk         (clk),
         .reset       (reset),
         .frame_start (frame_start_go),
         .clear       (state == PUBLISH),
         .count_en    (count_en),
         .pix_x       (p_x),
         .pix_y       (p_y),
         .pix_class   (p_class),
         .x0          (roi_x0[i*10 +: 10]),
         .x1          (roi_x1[i*10 +: 10]),
         .y0          (roi_y0[i*10 +: 10]),
         .y1          (roi_y1[i*10 +: 10]),
         .red_count   (red_cnt[i]),
         .green_count (green_cnt[i]),
         .blue_count  (blue_cnt[i])
`ifdef MULTI_ROI_WHITE_EN
         ,
         .white_count (white_cnt[i])
`endif
      );

      assign stable_color[i*2 +: 2] = stable_q[i];
`ifdef MULTI_ROI_WHITE_EN
      assign roi_white[i] = white_q[i];
`else
      assign roi_white[i] = 1'b0;
`endif
   end

   // Frame state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // A new frame start inside ACCUM restarts accumulation instead of evaluating.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (frame_start) next_state = ACCUM;
         ACCUM:   if (frame_start) next_state = ACCUM;
                  else if (last_pixel) next_state = EVAL;
         EVAL:    if (eval_idx == LAST_IDX) next_state = PUBLISH;
         PUBLISH: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Publish pulses are only visible for the single PUBLISH cycle.
   always_comb begin
      frame_done   = 1'b0;
      result_ready = '0;
      if (state == PUBLISH) begin
         frame_done   = 1'b1;
         result_ready = ready_flag;
      end
   end

   // Raw result for the ROI under evaluation; ties favour red, then green.
   always_comb begin
      sel_red    = red_cnt[eval_idx];
      sel_green  = green_cnt[eval_idx];
      sel_blue   = blue_cnt[eval_idx];
      best_color = RED;
      best_count = sel_red;
      if (!((sel_red >= sel_green) && (sel_red >= sel_blue))) begin
         if (sel_green >= sel_blue) begin
            best_color = GREEN;
            best_count = sel_green;
         end else begin
            best_color = BLUE;
            best_count = sel_blue;
         end
      end
      raw_color = NONE;
      if (best_count >= MIN_COUNT) raw_color = best_color;
`ifdef MULTI_ROI_WHITE_EN
      sel_white = white_cnt[eval_idx];
      raw_white = (sel_white >= WHITE_COUNT);
      same_raw  = (raw_color == prev_color[eval_idx]) &&
                  (raw_white == prev_white[eval_idx]);
`else
      same_raw  = (raw_color == prev_color[eval_idx]);
`endif
      new_match = 4'd1;
      if (same_raw) begin
         new_match = (match_cnt[eval_idx] == 4'hF) ? 4'hF : match_cnt[eval_idx] + 4'd1;
      end
   end

   // Stability tracking: one ROI per EVAL cycle, ready flags consumed by PUBLISH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         eval_idx   <= '0;
         ready_flag <= '0;
         for (int i = 0; i < NUM_ROI; i++) begin
            prev_color[i] <= NONE;
            stable_q[i]   <= NONE;
            match_cnt[i]  <= '0;
         end
`ifdef MULTI_ROI_WHITE_EN
         prev_white <= '0;
         white_q    <= '0;
`endif
      end else if (state == EVAL) begin
         eval_idx              <= eval_idx + 1'b1;
         match_cnt[eval_idx]   <= new_match;
         prev_color[eval_idx]  <= raw_color;
`ifdef MULTI_ROI_WHITE_EN
         prev_white[eval_idx]  <= raw_white;
`endif
         if (new_match >= STABLE_TARGET) begin
            stable_q[eval_idx]   <= raw_color;
            ready_flag[eval_idx] <= (raw_color != NONE) && (raw_color != stable_q[eval_idx]);
`ifdef MULTI_ROI_WHITE_EN
            white_q[eval_idx]    <= raw_white;
`endif
         end else begin
            ready_flag[eval_idx] <= 1'b0;
         end
      end else begin
         eval_idx <= '0;
         if (state == PUBLISH) ready_flag <= '0;
      end
   end

endmodule
